// File: rtl/reg_file_sb.sv
// Register file with per-register scoreboard busy bits,
// registered multi-port reads and optional write forwarding.
module reg_file_sb #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0]    rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_busy,
  input  logic                                 wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [REG_WIDTH-1:0]                 wr_data,
  input  logic                                 alloc_en,
  input  logic [REG_ADDR_WIDTH-1:0]            alloc_addr,
  output logic                                 alloc_hazard,
  input  logic                                 flush,
  output logic [REG_ADDR_WIDTH:0]              busy_count
);

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = REG_WIDTH;
  localparam int CW = REG_ADDR_WIDTH + 1;

  logic [DW-1:0]      regs [NUM_REG];
  logic [NUM_REG-1:0] busy;
  logic [NUM_REG-1:0] busy_nxt;
  logic [CW-1:0]      cnt_nxt;
  logic [NUM_RD_PORTS*DW-1:0] rdata_nxt;
  logic [NUM_RD_PORTS-1:0]    rbusy_nxt;
  logic [AW-1:0]      ra;
  logic               wr_ok;

  assign wr_ok        = wr_en && (wr_addr != '0);
  assign alloc_hazard = alloc_en && busy[alloc_addr];

  // Allocation outranks a same-cycle write; flush outranks both.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NUM_REG; r++) begin
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (alloc_en && alloc_addr == AW'(r))
        busy_nxt[r] = 1'b1;
      else if (wr_en && wr_addr == AW'(r))
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NUM_REG; r++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end

  always_comb begin
    rdata_nxt = '0;
    rbusy_nxt = '0;
    ra        = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (BYPASS != 0) begin
        if (wr_ok && wr_addr == ra)
          rdata_nxt[k*DW +: DW] = wr_data;
        else
          rdata_nxt[k*DW +: DW] = regs[ra];
        rbusy_nxt[k] = busy_nxt[ra];
      end else begin
        rdata_nxt[k*DW +: DW] = regs[ra];
        rbusy_nxt[k] = busy[ra];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REG; r++)
        regs[r] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
      rd_data    <= '0;
      rd_busy    <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
      rd_data    <= rdata_nxt;
      rd_busy    <= rbusy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb; a second
// instance with forwarding disabled shares the stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        alloc_hazard, nb_hazard;
  logic        flush;
  logic [5:0]  busy_count, nb_busy_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_hazard(alloc_hazard), .flush(flush),
    .busy_count(busy_count)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_hazard(nb_hazard), .flush(flush),
    .busy_count(nb_busy_count)
  );

  typedef struct {
    int unsigned we, wa;
    logic [31:0] wd;
    int unsigned ae, aa, fl, r0, r1;
    int unsigned hz;
    logic [31:0] d0, d1;
    int unsigned b0, b1, cnt;
    logic [31:0] nd0;
    int unsigned nb0;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    // we wa wd ae aa fl r0 r1 | hz d0 d1 b0 b1 cnt nd0 nb0
    vec[0]  = '{1, 5, 'hDEADBEEF, 0, 0, 0, 5, 0,
                0, 'hDEADBEEF, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0, 5, 5,
                0, 'hDEADBEEF, 'hDEADBEEF, 0, 0, 0, 'hDEADBEEF, 0};
    vec[2]  = '{1, 0, 'h1234, 0, 0, 0, 0, 5,
                0, 0, 'hDEADBEEF, 0, 0, 0, 0, 0};
    vec[3]  = '{1, 7, 'h55, 0, 0, 0, 7, 7,
                0, 'h55, 'h55, 0, 0, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0, 7, 0,
                0, 'h55, 0, 0, 0, 0, 'h55, 0};
    vec[5]  = '{0, 0, 0, 1, 3, 0, 3, 4,
                0, 0, 0, 1, 0, 1, 0, 0};
    vec[6]  = '{0, 0, 0, 1, 4, 0, 3, 4,
                0, 0, 0, 1, 1, 2, 0, 1};
    vec[7]  = '{1, 3, 'hAAAA0003, 0, 0, 0, 3, 4,
                0, 'hAAAA0003, 0, 0, 1, 1, 0, 1};
    vec[8]  = '{1, 4, 'h44, 1, 4, 0, 4, 3,
                1, 'h44, 'hAAAA0003, 1, 0, 1, 0, 1};
    vec[9]  = '{1, 4, 'h45, 0, 0, 0, 4, 9,
                0, 'h45, 0, 0, 0, 0, 'h44, 1};
    vec[10] = '{0, 0, 0, 1, 9, 0, 9, 9,
                0, 0, 0, 1, 1, 1, 0, 0};
    vec[11] = '{0, 0, 0, 1, 9, 0, 9, 9,
                1, 0, 0, 1, 1, 1, 0, 1};
    vec[12] = '{1, 11, 'h77, 1, 10, 1, 11, 10,
                0, 'h77, 0, 0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 0, 0, 10, 9,
                0, 0, 0, 0, 0, 0, 0, 0};
    vec[14] = '{0, 0, 0, 0, 0, 0, 11, 11,
                0, 'h77, 'h77, 0, 0, 0, 'h77, 0};
    vec[15] = '{1, 0, 'h99, 1, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b1;
    idle();
    rd_addr = '0;
    #12;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_busy", 64'(rd_busy), 64'h0);
    chk("rst_count", 64'(busy_count), 64'h0);
    chk("rst_nb_rd_data", nb_rd_data, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en      = vec[i].we[0];
      wr_addr    = vec[i].wa[4:0];
      wr_data    = vec[i].wd;
      alloc_en   = vec[i].ae[0];
      alloc_addr = vec[i].aa[4:0];
      flush      = vec[i].fl[0];
      rd_addr    = {vec[i].r1[4:0], vec[i].r0[4:0]};
      #1;
      chk($sformatf("v%0d_hazard", i), 64'(alloc_hazard),
          64'(vec[i].hz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_d0", i), 64'(rd_data[31:0]), 64'(vec[i].d0));
      chk($sformatf("v%0d_d1", i), 64'(rd_data[63:32]), 64'(vec[i].d1));
      chk($sformatf("v%0d_b0", i), 64'(rd_busy[0]), 64'(vec[i].b0));
      chk($sformatf("v%0d_b1", i), 64'(rd_busy[1]), 64'(vec[i].b1));
      chk($sformatf("v%0d_cnt", i), 64'(busy_count), 64'(vec[i].cnt));
      chk($sformatf("v%0d_nb_d0", i), 64'(nb_rd_data[31:0]),
          64'(vec[i].nd0));
      chk($sformatf("v%0d_nb_b0", i), 64'(nb_rd_busy[0]),
          64'(vec[i].nb0));
    end

    // Fill every register, then allocate all of them.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
      @(posedge clk);
    end
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      idle();
      alloc_en = 1'b1; alloc_addr = 5'(i);
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    rd_addr = {5'd31, 5'd1};
    #1;
    chk("full_hazard_idle", 64'(alloc_hazard), 64'h0);
    @(posedge clk);
    #1;
    chk("full_count", 64'(busy_count), 64'd31);
    chk("full_d0", 64'(rd_data[31:0]), 64'h1001);
    chk("full_d1", 64'(rd_data[63:32]), 64'h101F);
    chk("full_busy", 64'(rd_busy), 64'h3);

    @(negedge clk);
    alloc_en = 1'b1; alloc_addr = 5'd31;
    #1;
    chk("realloc_hazard", 64'(alloc_hazard), 64'h1);
    @(posedge clk);
    #1;
    chk("realloc_count", 64'(busy_count), 64'd31);

    // Reset between edges, held across an edge with live strobes.
    @(negedge clk);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rd_data", rd_data, 64'h0);
    chk("async_rd_busy", 64'(rd_busy), 64'h0);
    chk("async_count", 64'(busy_count), 64'h0);
    chk("async_nb_rd_data", nb_rd_data, 64'h0);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd2;
    @(posedge clk);
    #1;
    chk("held_count", 64'(busy_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    rd_addr = {5'd2, 5'd1};
    @(posedge clk);
    #1;
    chk("post_rst_data", rd_data, 64'h0);
    chk("post_rst_busy", 64'(rd_busy), 64'h0);
    chk("post_rst_count", 64'(busy_count), 64'h0);
    chk("post_rst_nb_data", nb_rd_data, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NUM_REG, default 32, number of architectural registers (power of two, >=4).
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, equal to log2(NUM_REG).
REQ-003 SHALL have parameter REG_WIDTH, default 32, data width.
REQ-004 SHALL have parameter NUM_RD_PORTS, default 2, read port count (1..4).
REQ-005 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding, 0 = none.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  clock, rising edge active.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 rd_addr  input  NUM_RD_PORTS*REG_ADDR_WIDTH  read addresses, port k in slice k.
REQ-010 rd_data  output  NUM_RD_PORTS*REG_WIDTH  registered read data, port k in slice k.
REQ-011 rd_busy  output  NUM_RD_PORTS  registered scoreboard busy flag per read port.
REQ-012 wr_en  input  1  write strobe; writes also clear the busy bit.
REQ-013 wr_addr  input  REG_ADDR_WIDTH  write address.
REQ-014 wr_data  input  REG_WIDTH  write data.
REQ-015 alloc_en  input  1  issue strobe; marks alloc_addr busy (pending write).
REQ-016 alloc_addr  input  REG_ADDR_WIDTH  destination being allocated.
REQ-017 alloc_hazard  output  1  combinational: alloc_en=1 and busy[alloc_addr]=1 (WAW).
REQ-018 flush  input  1  clears all busy bits; register data untouched.
REQ-019 busy_count  output  REG_ADDR_WIDTH+1  registered number of set busy bits.

Function
REQ-020 Register 0 SHALL read as 0, ignore writes, never become busy.
REQ-021 Write: on rising edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
REQ-022 Read latency SHALL be one cycle: rd_data/rd_busy update on each rising edge from rd_addr sampled at that edge.
REQ-023 BYPASS=1: each port SHALL capture post-edge state, i.e. wr_data if wr_en and wr_addr==rd_addr!=0, and busy next-state for rd_busy.
REQ-024 BYPASS=0: each port SHALL capture pre-edge register value and busy bit.
REQ-025 Busy next-state per register r!=0: flush -> 0; else alloc_en and alloc_addr==r -> 1; else wr_en and wr_addr==r -> 0; else hold.
REQ-026 Simultaneous alloc and write to same register SHALL leave it busy (new allocation wins).
REQ-027 alloc_en with alloc_hazard=1 SHALL still be accepted (bit stays 1, count unchanged).
REQ-028 flush in same cycle as wr_en SHALL still perform the data write; alloc in a flush cycle SHALL be dropped.
REQ-029 busy_count SHALL equal popcount of busy bits after each edge: +1 per newly set, -1 per newly cleared, 0 on flush; never exceeds NUM_REG-1, never negative.
REQ-030 Multiple read ports to the same address SHALL return identical data and busy.
REQ-031 alloc_addr=0 and wr_addr=0 SHALL have no effect on busy state or busy_count.

Reset
REQ-032 reset=1 SHALL immediately clear all registers, all busy bits, rd_data, rd_busy and busy_count to 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard any same-cycle write, alloc or flush; first post-reset edge behaves as from an empty file.

Verification
REQ-034 Write 0xDEADBEEF to r5, next cycle rd_addr port0=5 -> rd_data port0=0xDEADBEEF one edge later; write r0=0x1234 -> reads 0.
REQ-035 BYPASS=1: wr r7=0x55 and rd r7 same edge -> rd_data=0x55 after that edge; BYPASS=0 same stimulus -> old value.
REQ-036 alloc r3, r4 -> busy_count=2, rd_busy for r3=1; wr r3 -> busy_count=1; alloc+wr r4 same cycle -> r4 busy, count 1.
REQ-037 alloc r9 twice -> second cycle alloc_hazard=1, busy_count=1; flush with alloc r10 and wr r11=0x77 -> busy_count=0, r11=0x77, r10 not busy.
REQ-038 Load r1..r31, allocate 31 registers -> busy_count=31; assert reset between edges -> all outputs 0 immediately, reads of r1 return 0.
